// File: rtl/udp_tx_pkt_ctrl.sv
// Packet controller on the read side of the UDP TX FIFO: decides when a packet is
// ready (full or idle-timeout), starts the UDP core and feeds it one word per tx_req.
module udp_tx_pkt_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int PKT_WORDS   = 256,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
    output logic                  fifo_rd_en,
    output logic                  tx_start_en,
    output logic [15:0]           tx_byte_num,
    input  logic                  tx_req,
    output logic [31:0]           tx_data,
    input  logic                  tx_done,
    output logic                  busy,
    output logic [15:0]           pkt_cnt,
    output logic                  err_flag
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] PKT_LEN      = LW'(PKT_WORDS);
    localparam logic [15:0]   TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SEND,
        WAIT_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  word_cnt_q, word_cnt_d;
    logic [15:0]    timeout_q, timeout_d;
    logic           tx_start_en_q, tx_start_en_d;
    logic [15:0]    tx_byte_num_q, tx_byte_num_d;
    logic [31:0]    tx_data_q, tx_data_d;
    logic [15:0]    pkt_cnt_q, pkt_cnt_d;
    logic           err_flag_q, err_flag_d;
    logic           busy_q, busy_d;

    logic           launch;
    logic [LW-1:0]  launch_len;
    logic [31:0]    launch_bytes;
    logic           rd_en_c;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d       = state_q;
        len_d         = len_q;
        word_cnt_d    = word_cnt_q;
        timeout_d     = '0;
        tx_start_en_d = 1'b0;
        tx_byte_num_d = tx_byte_num_q;
        tx_data_d     = tx_data_q;
        pkt_cnt_d     = pkt_cnt_q;
        err_flag_d    = err_flag_q;
        rd_en_c       = 1'b0;
        launch        = 1'b0;
        launch_len    = '0;
        launch_bytes  = '0;

        case (state_q)
            IDLE: begin
                // A full packet wins over an expiring timeout on the same cycle.
                if (fifo_rd_water_level >= PKT_LEN) begin
                    launch     = 1'b1;
                    launch_len = PKT_LEN;
                end else if (fifo_rd_water_level != '0) begin
                    if (timeout_q == TIMEOUT_LAST) begin
                        launch     = 1'b1;
                        launch_len = fifo_rd_water_level;
                    end else begin
                        timeout_d = timeout_q + 16'd1;
                    end
                end
            end

            START: begin
                word_cnt_d = '0;
                state_d    = SEND;
            end

            SEND: begin
                if (tx_req && (word_cnt_q < len_q)) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (!fifo_empty) begin
                        rd_en_c   = 1'b1;
                        tx_data_d = fifo_rd_data;
                    end else begin
                        // Underrun: keep the packet length, send a zero word, flag it.
                        tx_data_d  = '0;
                        err_flag_d = 1'b1;
                    end
                    if (word_cnt_d == len_q) begin
                        state_d = WAIT_DONE;
                    end
                end
                if (tx_done) begin
                    err_flag_d = 1'b1;
                    state_d    = IDLE;
                end
            end

            WAIT_DONE: begin
                if (tx_done) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    state_d   = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Byte count is loaded with the start pulse so it is valid while tx_start_en is high.
        if (launch) begin
            launch_bytes  = 32'({launch_len, 2'b00});
            len_d         = launch_len;
            tx_byte_num_d = launch_bytes[15:0];
            tx_start_en_d = 1'b1;
            state_d       = START;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            len_q         <= '0;
            word_cnt_q    <= '0;
            timeout_q     <= '0;
            tx_start_en_q <= 1'b0;
            tx_byte_num_q <= '0;
            tx_data_q     <= '0;
            pkt_cnt_q     <= '0;
            err_flag_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            len_q         <= len_d;
            word_cnt_q    <= word_cnt_d;
            timeout_q     <= timeout_d;
            tx_start_en_q <= tx_start_en_d;
            tx_byte_num_q <= tx_byte_num_d;
            tx_data_q     <= tx_data_d;
            pkt_cnt_q     <= pkt_cnt_d;
            err_flag_q    <= err_flag_d;
            busy_q        <= busy_d;
        end
    end

    assign fifo_rd_en  = rd_en_c;
    assign tx_start_en = tx_start_en_q;
    assign tx_byte_num = tx_byte_num_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign err_flag    = err_flag_q;

endmodule

// File: tb/tb_udp_tx_pkt_ctrl.sv
// Bench for udp_tx_pkt_ctrl: a small-packet instance fed by a FIFO model and a
// 256-word instance driven directly for timeout-clear and priority corners.
module tb_udp_tx_pkt_ctrl;

    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Instance A: PKT_WORDS=4, TIMEOUT_CYC=100, fed by a FIFO model
    logic          rst_a_n = 1'b0;
    logic [31:0]   a_data;
    logic          a_empty;
    logic [AW:0]   a_level;
    logic          a_rd_en, a_start, a_busy, a_err;
    logic [15:0]   a_bytes, a_pkt_cnt;
    logic          a_req  = 1'b0;
    logic          a_done = 1'b0;
    logic [31:0]   a_tx_data;

    logic [31:0]   mem [0:63];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;
    logic          force_empty = 1'b0;
    logic          fifo_clr    = 1'b0;

    assign a_level = (AW + 1)'(wr_ptr - rd_ptr);
    assign a_empty = (wr_ptr == rd_ptr) || force_empty;
    assign a_data  = mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (fifo_clr)     rd_ptr <= wr_ptr;
        else if (a_rd_en) rd_ptr <= rd_ptr + 1;
    end

    udp_tx_pkt_ctrl #(.ADDR_WIDTH(AW), .PKT_WORDS(4), .TIMEOUT_CYC(100)) dut_a (
        .clk(clk), .rst_n(rst_a_n),
        .fifo_rd_data(a_data), .fifo_empty(a_empty), .fifo_rd_water_level(a_level),
        .fifo_rd_en(a_rd_en), .tx_start_en(a_start), .tx_byte_num(a_bytes),
        .tx_req(a_req), .tx_data(a_tx_data), .tx_done(a_done),
        .busy(a_busy), .pkt_cnt(a_pkt_cnt), .err_flag(a_err)
    );

    // Instance B: PKT_WORDS=256, TIMEOUT_CYC=100, level driven directly
    logic          rst_b_n = 1'b0;
    logic [31:0]   b_data  = '0;
    logic          b_empty;
    logic [AW:0]   b_level = '0;
    logic          b_rd_en, b_start, b_busy, b_err;
    logic [15:0]   b_bytes, b_pkt_cnt;
    logic          b_req  = 1'b0;
    logic          b_done = 1'b0;
    logic [31:0]   b_tx_data;

    assign b_empty = (b_level == '0);

    udp_tx_pkt_ctrl #(.ADDR_WIDTH(AW), .PKT_WORDS(256), .TIMEOUT_CYC(100)) dut_b (
        .clk(clk), .rst_n(rst_b_n),
        .fifo_rd_data(b_data), .fifo_empty(b_empty), .fifo_rd_water_level(b_level),
        .fifo_rd_en(b_rd_en), .tx_start_en(b_start), .tx_byte_num(b_bytes),
        .tx_req(b_req), .tx_data(b_tx_data), .tx_done(b_done),
        .busy(b_busy), .pkt_cnt(b_pkt_cnt), .err_flag(b_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_a(input int n, input logic [31:0] base);
        for (int j = 0; j < n; j++) begin
            mem[wr_ptr[5:0]] = base + 32'h11 * j;
            wr_ptr++;
        end
    endtask

    // Waits for the start pulse, then leaves the bench at the first negedge in SEND.
    task automatic expect_start_a(input string name, input int exp_lat, input logic [15:0] exp_bytes);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!a_start && lat < 400);
        check({name, " start"}, 32'(a_start), 32'd1);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " byte_num"}, 32'(a_bytes), 32'(exp_bytes));
        check({name, " busy"}, 32'(a_busy), 32'd1);
        @(negedge clk);
        check({name, " start one cycle"}, 32'(a_start), 32'd0);
    endtask

    task automatic req_a(input string name, input int n, input int n_valid, input logic [31:0] first);
        logic [31:0] exp;
        a_req = 1'b1;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            exp = first + 32'h11 * ((j < n_valid) ? j : n_valid - 1);
            check($sformatf("%s data%0d", name, j), a_tx_data, exp);
            if (j == n - 1) a_req = 1'b0;
        end
    endtask

    task automatic done_a(input string name, input logic [15:0] exp_cnt);
        a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        check({name, " busy after done"}, 32'(a_busy), 32'd0);
        check({name, " pkt_cnt"}, 32'(a_pkt_cnt), 32'(exp_cnt));
    endtask

    task automatic reset_a();
        a_req       = 1'b0;
        a_done      = 1'b0;
        force_empty = 1'b0;
        rst_a_n     = 1'b0;
        fifo_clr    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        fifo_clr    = 1'b0;
        rst_a_n     = 1'b1;
    endtask

    typedef struct {
        int          nwords;
        int          nreq;
        int          exp_lat;
        logic [15:0] exp_bytes;
        logic [31:0] base;
    } vec_t;

    vec_t        vecs [5];
    int unsigned rp0, rp1;
    int          lat;
    logic [15:0] exp_pkt;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4, 4, 1,   16'd16, 32'h11};   // full packet
        vecs[1] = '{3, 3, 100, 16'd12, 32'h100};  // timeout flush
        vecs[2] = '{4, 6, 1,   16'd16, 32'h11};   // excess requests
        vecs[3] = '{1, 1, 100, 16'd4,  32'h200};  // single-word flush
        vecs[4] = '{2, 3, 100, 16'd8,  32'h300};  // flush plus one excess request

        repeat (2) @(negedge clk);
        check("rst tx_start_en", 32'(a_start), 32'd0);
        check("rst tx_byte_num", 32'(a_bytes), 32'd0);
        check("rst tx_data", a_tx_data, 32'd0);
        check("rst busy", 32'(a_busy), 32'd0);
        check("rst pkt_cnt", 32'(a_pkt_cnt), 32'd0);
        check("rst err_flag", 32'(a_err), 32'd0);
        check("rst fifo_rd_en", 32'(a_rd_en), 32'd0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        exp_pkt = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rp0 = rd_ptr;
            push_a(vecs[i].nwords, vecs[i].base);
            expect_start_a($sformatf("vec%0d", i), vecs[i].exp_lat, vecs[i].exp_bytes);
            req_a($sformatf("vec%0d", i), vecs[i].nreq, vecs[i].nwords, vecs[i].base);
            check($sformatf("vec%0d pops", i), rd_ptr - rp0, 32'(vecs[i].nwords));
            check($sformatf("vec%0d fifo empty", i), 32'(a_level), 32'd0);
            check($sformatf("vec%0d err_flag", i), 32'(a_err), 32'd0);
            exp_pkt++;
            done_a($sformatf("vec%0d", i), exp_pkt);
        end

        // Underrun on the third word
        @(negedge clk);
        rp0 = rd_ptr;
        push_a(4, 32'h500);
        expect_start_a("underrun", 1, 16'd16);
        a_req = 1'b1;
        @(negedge clk);
        check("underrun data0", a_tx_data, 32'h500);
        @(negedge clk);
        check("underrun data1", a_tx_data, 32'h511);
        force_empty = 1'b1;
        rp1 = rd_ptr;
        @(negedge clk);
        check("underrun data zero", a_tx_data, 32'h0);
        check("underrun err_flag", 32'(a_err), 32'd1);
        check("underrun no pop", rd_ptr - rp1, 32'd0);
        force_empty = 1'b0;
        @(negedge clk);
        a_req = 1'b0;
        check("underrun data3", a_tx_data, 32'h522);
        check("underrun pops", rd_ptr - rp0, 32'd3);
        exp_pkt++;
        done_a("underrun", exp_pkt);
        check("underrun err sticky", 32'(a_err), 32'd1);
        reset_a();
        check("err cleared by reset", 32'(a_err), 32'd0);

        // tx_done after 2 of 4 words
        @(negedge clk);
        rp0 = rd_ptr;
        push_a(4, 32'h600);
        expect_start_a("early", 1, 16'd16);
        req_a("early", 2, 2, 32'h600);
        a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        check("early busy", 32'(a_busy), 32'd0);
        check("early pkt_cnt", 32'(a_pkt_cnt), 32'd0);
        check("early err_flag", 32'(a_err), 32'd1);
        check("early pops", rd_ptr - rp0, 32'd2);
        reset_a();

        // Asynchronous reset mid-SEND, then the two remaining words go out as a partial packet
        @(negedge clk);
        rp0 = rd_ptr;
        push_a(4, 32'h700);
        expect_start_a("midrst", 1, 16'd16);
        req_a("midrst", 2, 2, 32'h700);
        #2 rst_a_n = 1'b0;
        #1;
        check("midrst tx_start_en", 32'(a_start), 32'd0);
        check("midrst tx_byte_num", 32'(a_bytes), 32'd0);
        check("midrst tx_data", a_tx_data, 32'd0);
        check("midrst busy", 32'(a_busy), 32'd0);
        check("midrst pkt_cnt", 32'(a_pkt_cnt), 32'd0);
        check("midrst err_flag", 32'(a_err), 32'd0);
        check("midrst fifo_rd_en", 32'(a_rd_en), 32'd0);
        @(negedge clk);
        rst_a_n = 1'b1;
        expect_start_a("resume", 100, 16'd8);
        req_a("resume", 2, 2, 32'h722);
        check("resume pops", rd_ptr - rp0, 32'd4);
        check("resume fifo empty", 32'(a_level), 32'd0);
        done_a("resume", 16'd1);

        // Instance B: level drop clears the timeout, then flush of 3 words
        @(negedge clk);
        b_level = 11'd3;
        repeat (50) @(negedge clk);
        b_level = 11'd0;
        @(negedge clk);
        b_level = 11'd3;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!b_start && lat < 400);
        check("b flush start", 32'(b_start), 32'd1);
        check("b flush latency", 32'(lat), 32'd100);
        check("b flush byte_num", 32'(b_bytes), 32'd12);
        @(negedge clk);
        b_data = 32'hA0;
        b_req  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("b flush data%0d", j), b_tx_data, 32'hA0 + 32'(j));
            b_data = 32'hA0 + 32'(j + 1);
            if (j == 2) b_req = 1'b0;
        end
        b_level = 11'd0;
        b_done  = 1'b1;
        @(negedge clk);
        b_done = 1'b0;
        check("b flush busy", 32'(b_busy), 32'd0);
        check("b flush pkt_cnt", 32'(b_pkt_cnt), 32'd1);

        // Level reaches 256 on the cycle the timeout expires: full packet wins
        b_level = 11'd3;
        repeat (99) @(negedge clk);
        check("b prio no early start", 32'(b_busy), 32'd0);
        b_level = 11'd256;
        @(negedge clk);
        check("b prio start", 32'(b_start), 32'd1);
        check("b prio byte_num", 32'(b_bytes), 32'd1024);
        check("b err_flag", 32'(b_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
